// File: rtl/cpu_ctrl_fsm_if.sv
// Control-unit bus: instruction fetch handshake, datapath strobes and status.
// The control FSM is the master; the datapath/memory side is the slave.
interface cpu_ctrl_fsm_if;
   logic [7:0] imem_data_i;
   logic       imem_valid_i;
   logic [7:0] alu_y_i;
   logic       imem_req_o;
   logic [2:0] mux_select_o;
   logic [4:0] op_o;
   logic       alu_sub_o;
   logic       reg_a_load_o;
   logic       reg_b_load_o;
   logic       pc_inc_o;
   logic       pc_load_o;
   logic       zero_o;
   logic       halted_o;
   logic       fault_o;

   modport master (
      input  imem_data_i, imem_valid_i, alu_y_i,
      output imem_req_o, mux_select_o, op_o, alu_sub_o,
      output reg_a_load_o, reg_b_load_o, pc_inc_o, pc_load_o,
      output zero_o, halted_o, fault_o
   );

   modport slave (
      output imem_data_i, imem_valid_i, alu_y_i,
      input  imem_req_o, mux_select_o, op_o, alu_sub_o,
      input  reg_a_load_o, reg_b_load_o, pc_inc_o, pc_load_o,
      input  zero_o, halted_o, fault_o
   );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU: fetch, decode, execute, writeback.
// Holds IR, zero flag and fetch-timeout fault; drives all datapath strobes.
module cpu_ctrl_fsm #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter bit ZERO_ON_LOAD   = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   cpu_ctrl_fsm_if.master bus
);
   localparam logic [2:0] MUX_SELECT_NONE  = 3'd0;
   localparam logic [2:0] MUX_SELECT_PC    = 3'd1;
   localparam logic [2:0] MUX_SELECT_OP    = 3'd2;
   localparam logic [2:0] MUX_SELECT_ALU_Y = 3'd3;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_LDB = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_JZ  = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_t;

   state_t        r_state;
   logic [7:0]    r_ir;
   logic          r_zero;
   logic [CW-1:0] r_cnt;
   logic          r_fault;

   logic [2:0] w_opc;
   logic       w_req;
   logic [2:0] w_mux;
   logic       w_sub;
   logic       w_a_load;
   logic       w_b_load;
   logic       w_pc_inc;
   logic       w_pc_load;

   assign w_opc = r_ir[7:5];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_FETCH;
         r_ir    <= 8'd0;
         r_zero  <= 1'b0;
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (bus.imem_valid_i) begin
                  r_ir    <= bus.imem_data_i;
                  r_cnt   <= '0;
                  r_state <= S_DECODE;
               end else if (r_cnt == CNT_LAST) begin
                  r_fault <= 1'b1;
                  r_state <= S_HALT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DECODE: r_state <= S_EXEC;
            S_EXEC: begin
               r_state <= S_FETCH;
               case (w_opc)
                  OP_LDA: begin
                     if (ZERO_ON_LOAD)
                        r_zero <= (r_ir[4:0] == 5'd0);
                  end
                  OP_ADD, OP_SUB: r_state <= S_WB;
                  OP_HLT:         r_state <= S_HALT;
                  default: ;
               endcase
            end
            S_WB: begin
               r_zero  <= (bus.alu_y_i == 8'd0);
               r_state <= S_FETCH;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Strobes are gated by reset so a reset landing in WB never loads A.
   always_comb begin
      w_req     = 1'b0;
      w_mux     = MUX_SELECT_NONE;
      w_sub     = 1'b0;
      w_a_load  = 1'b0;
      w_b_load  = 1'b0;
      w_pc_inc  = 1'b0;
      w_pc_load = 1'b0;
      if (!rst_i) begin
         case (r_state)
            S_FETCH: begin
               w_req    = 1'b1;
               w_mux    = MUX_SELECT_PC;
               w_pc_inc = bus.imem_valid_i;
            end
            S_EXEC: begin
               case (w_opc)
                  OP_LDA: begin
                     w_mux    = MUX_SELECT_OP;
                     w_a_load = 1'b1;
                  end
                  OP_LDB: begin
                     w_mux    = MUX_SELECT_OP;
                     w_b_load = 1'b1;
                  end
                  OP_ADD, OP_SUB: w_sub = w_opc[2];
                  OP_JMP: begin
                     w_mux     = MUX_SELECT_OP;
                     w_pc_load = 1'b1;
                  end
                  OP_JZ: begin
                     if (r_zero) begin
                        w_mux     = MUX_SELECT_OP;
                        w_pc_load = 1'b1;
                     end
                  end
                  OP_NOP, OP_HLT: ;
                  default: ;
               endcase
            end
            S_WB: begin
               w_sub    = w_opc[2];
               w_mux    = MUX_SELECT_ALU_Y;
               w_a_load = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req_o   = w_req;
   assign bus.mux_select_o = w_mux;
   assign bus.op_o         = r_ir[4:0];
   assign bus.alu_sub_o    = w_sub;
   assign bus.reg_a_load_o = w_a_load;
   assign bus.reg_b_load_o = w_b_load;
   assign bus.pc_inc_o     = w_pc_inc;
   assign bus.pc_load_o    = w_pc_load;
   assign bus.zero_o       = r_zero;
   assign bus.halted_o     = (r_state == S_HALT);
   assign bus.fault_o      = r_fault;
endmodule
